// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
//   ibus_req_o   master->slave  request, held stable until the ack cycle
//   ibus_addr_o  master->slave  fetch address, held stable until the ack cycle
//   ibus_ack_i   slave->master  read data valid this cycle (ignored without req)
//   ibus_data_i  slave->master  read data
interface if_fetch_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_data_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_ack_i,
    input  ibus_data_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_ack_i,
    output ibus_data_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, masters the instruction bus and
// presents fetched instructions to the IF/ID register.
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        pipeline stall vector, stall[0] holds the PC stage
//   flush, new_pc     exception/interrupt redirect (highest priority)
//   branch_flag_i,
//   branch_target_i   taken-branch redirect from ID
//   ibus              instruction bus (master side)
//   if_pc, if_inst    presented PC/instruction (zero = bubble)
//   stallreq_o        fetch not complete, stall the pipeline
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic [31:0]      new_pc,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  if_fetch_if.master       ibus,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             stallreq_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  // Only stall[0] concerns the PC stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // Flush beats branch; sequential increment wraps naturally.
  assign redirect = flush | branch_flag_i;
  assign target   = flush ? new_pc : branch_target_i;
  assign pc_inc   = pc_q + XLEN'(4);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Next-state, next-datapath and output mux.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    addr_d           = addr_q;
    hold_pc_d        = hold_pc_q;
    hold_inst_d      = hold_inst_q;
    ibus.ibus_req_o  = 1'b0;
    ibus.ibus_addr_o = '0;
    if_pc            = '0;
    if_inst          = '0;
    stallreq_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        addr_d  = pc_q;
      end

      S_WAIT: begin
        ibus.ibus_req_o  = 1'b1;
        ibus.ibus_addr_o = addr_q;
        if (redirect) begin
          // Redirect cycle: bubble, controller is already flushing.
          pc_d = target;
          if (ibus.ibus_ack_i) begin
            addr_d = target;
          end else begin
            // Bus cycle must finish on the stale address first.
            state_d = S_DROP;
          end
        end else if (ibus.ibus_ack_i) begin
          if_pc   = addr_q;
          if_inst = ibus.ibus_data_i;
          if (stall[0]) begin
            hold_pc_d   = addr_q;
            hold_inst_d = ibus.ibus_data_i;
            state_d     = S_HOLD;
          end else begin
            pc_d   = pc_inc;
            addr_d = pc_inc;
          end
        end else begin
          stallreq_o = 1'b1;
        end
      end

      S_HOLD: begin
        if_pc   = hold_pc_q;
        if_inst = hold_inst_q;
        if (redirect) begin
          pc_d    = target;
          addr_d  = target;
          state_d = S_WAIT;
        end else if (!stall[0]) begin
          pc_d    = pc_inc;
          addr_d  = pc_inc;
          state_d = S_WAIT;
        end
      end

      S_DROP: begin
        ibus.ibus_req_o  = 1'b1;
        ibus.ibus_addr_o = addr_q;
        stallreq_o       = !redirect;
        if (redirect) begin
          pc_d = target;
        end
        if (ibus.ibus_ack_i) begin
          // Stale data discarded; resume at the latest redirect target.
          addr_d  = redirect ? target : pc_q;
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
